// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO built as a circular buffer with an occupancy counter.
// Latency: 1 cycle enqueue->v_o. Backpressure: ready_o drops when full, independent of yumi_i.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 32,
    parameter int els_p   = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                enq, deq;

    assign ready_o = (cnt_q != full_cnt_lp);
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Gate with reset so the storage is not written while reset is held.
    assign enq = v_i & ready_o & reset_i;
    assign deq = yumi_i & v_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_w_lp'(1);
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + ptr_w_lp'(1);
        end
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
            2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_bsg_fifo_1r1w_small.sv
// Directed bench for bsg_fifo_1r1w_small with a queue scoreboard as the reference.
module tb_bsg_fifo_1r1w_small;

    localparam int W = 32;
    localparam int N = 32;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         v_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         ready_o;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         yumi_i = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb[$];

    bsg_fifo_1r1w_small #(.width_p(W), .els_p(N)) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (v_i),
        .data_i (data_i),
        .ready_o(ready_o),
        .v_o    (v_o),
        .data_o (data_o),
        .yumi_i (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called mid-cycle: drive inputs, check outputs against the model, take one edge.
    task automatic drive(input string tag, input logic v, input logic [W-1:0] d, input logic y);
        bit do_enq, do_deq;
        v_i    = v;
        data_i = d;
        yumi_i = y;
        chk({tag, ".ready"}, {31'b0, ready_o}, {31'b0, sb.size() < N});
        chk({tag, ".v"},     {31'b0, v_o},     {31'b0, sb.size() > 0});
        do_enq = v && (sb.size() < N);
        do_deq = y && (sb.size() > 0);
        if (do_deq) chk({tag, ".data"}, data_o, sb[0]);
        @(posedge clk_i);
        #1;
        if (do_deq) void'(sb.pop_front());
        if (do_enq) sb.push_back(d);
        v_i    = 1'b0;
        yumi_i = 1'b0;
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #2 reset_i = 1'b0;
        #1;
        chk("async_rst.v", {31'b0, v_o}, 32'd0);
        chk("async_rst.ready", {31'b0, ready_o}, 32'd1);
        v_i = 1'b1; data_i = 32'h1234; yumi_i = 1'b1;
        repeat (10) begin
            @(posedge clk_i);
            #1;
            chk("rst_hold.v", {31'b0, v_o}, 32'd0);
            chk("rst_hold.ready", {31'b0, ready_o}, 32'd1);
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        v_i = 1'b0; yumi_i = 1'b0;
        drive("idle0", 1'b0, '0, 1'b0);
        drive("idle1", 1'b0, '0, 1'b0);

        // Latency: enqueue into empty FIFO, visible right after the edge.
        drive("lat_enq", 1'b1, 32'hA5, 1'b0);
        chk("lat.v_after", {31'b0, v_o}, 32'd1);
        chk("lat.data_after", data_o, 32'hA5);
        drive("lat_deq", 1'b0, '0, 1'b1);
        drive("empty_yumi", 1'b0, '0, 1'b1);

        // Fill back-to-back, then an overflow attempt.
        for (int i = 0; i < N; i++) drive("fill", 1'b1, i, 1'b0);
        chk("full.ready", {31'b0, ready_o}, 32'd0);
        drive("overflow", 1'b1, 32'hDEAD, 1'b0);

        // Full with simultaneous yumi and valid: head leaves, incoming dropped.
        drive("full_yumi", 1'b1, 32'h99, 1'b1);
        chk("full_yumi.ready_next", {31'b0, ready_o}, 32'd1);
        chk("full_yumi.occ", sb.size(), 32'd31);

        for (int i = 1; i < N; i++) drive("drain", 1'b0, '0, 1'b1);
        chk("drained.v", {31'b0, v_o}, 32'd0);

        // Streaming at occupancy 1; pointers wrap several times.
        drive("stream_pre", 1'b1, 32'd1000, 1'b0);
        for (int i = 0; i < 100; i++) drive("stream", 1'b1, 32'd1001 + i, 1'b1);
        chk("stream.occ", sb.size(), 32'd1);
        drive("stream_end", 1'b0, '0, 1'b1);
        chk("stream_end.v", {31'b0, v_o}, 32'd0);

        // Mid-run reset with occupancy 5.
        for (int i = 0; i < 5; i++) drive("pre_rst", 1'b1, 32'h50 + i, 1'b0);
        reset_i = 1'b0;
        v_i = 1'b1; data_i = 32'hBEEF; yumi_i = 1'b1;
        #1;
        chk("mid_rst.v", {31'b0, v_o}, 32'd0);
        chk("mid_rst.ready", {31'b0, ready_o}, 32'd1);
        sb.delete();
        @(posedge clk_i);
        #1;
        chk("mid_rst_edge.v", {31'b0, v_o}, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        v_i = 1'b0; yumi_i = 1'b0;
        drive("post_rst_idle", 1'b0, '0, 1'b0);
        drive("post_rst_enq", 1'b1, 32'h7, 1'b0);
        chk("post_rst.data", data_o, 32'h7);
        drive("post_rst_deq", 1'b0, '0, 1'b1);
        drive("post_rst_empty", 1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
